des_core_arbiter: RTL
=====================

# des_core_arbiter

Shares one iterative DES core between two requester channels. Performs round-robin arbitration, sequences the core's 16 rounds via `des_roundSel`, and captures the result. Provides optional per-channel CBC chaining. Sits between the host-side buffer engines (PipeIn/PipeOut RAM movers) and the single `des` instance on `clk1`. The key is not handled here; it is wired to the core directly.

## Interface
Parameters:
- `CHAIN_EN`, default 1: 1 enables CBC chaining logic; 0 ties the chain XOR to zero and ignores `reqN_chain` and `iv_load`.

Ports (N = 0, 1):
- `clk1`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `reqN_valid`, input, 1: channel N has a block to process.
- `reqN_ready`, output, 1: channel N block accepted this cycle.
- `reqN_data`, input, 64: input block.
- `reqN_decrypt`, input, 1: 1 = decrypt, 0 = encrypt.
- `reqN_chain`, input, 1: apply CBC for this block.
- `rspN_valid`, output, 1: result available for channel N.
- `rspN_ready`, input, 1: channel N consumes the result.
- `rspN_data`, output, 64: result block.
- `iv`, input, 64: shared IV bus.
- `iv_load`, input, 2: bit N loads `chainN` from `iv`.
- `des_in`, output, 64: to core `desIn`.
- `des_decrypt`, output, 1: to core `decrypt`.
- `des_roundSel`, output, 4: to core `roundSel`.
- `des_out`, input, 64: from core `desOut`.
- `busy`, output, 1: high in any state other than IDLE.
- `grant_id`, output, 1: channel owning the core (valid while busy).

## Operation
- **States:** IDLE, RUN, RESP.
- **IDLE: grant.**
  - If neither channel is valid: stay in IDLE with both `reqN_ready` = 0.
  - If exactly one channel is valid: grant that channel.
  - If both are valid: grant the channel other than `last_grant`.
  - `reqN_ready` is combinational: it is 1 only for the granted channel while in IDLE. A transfer is `valid & ready`.
  - On the accept edge:
    - `grant_id` <= N.
    - `saved_in` <= `reqN_data`.
    - `x` <= (`CHAIN_EN` & `chain` ? `chainN` : 0).
    - `des_in` <= `reqN_data` ^ (encrypt ? `x` : 0).
    - `des_decrypt` <= `reqN_decrypt`.
    - `des_roundSel` <= 0.
    - Next state is RUN.
- **RUN:** `des_roundSel` increments by 1 per cycle. In the cycle where `des_roundSel` == 15:
  - Capture `result` = `des_out` ^ (decrypt ? `x` : 0) into `rspN_data`.
  - If chained, update `chainN`: encrypt -> `result`; decrypt -> `saved_in`.
  - Next state is RESP.
- **RESP:**
  - `rspN_valid` = 1 (granted channel only).
  - On `rspN_ready`: `rspN_valid` <= 0, `last_grant` <= `grant_id`, next state is IDLE.
  - Results are held stable until consumed.
  - No new block is accepted while in RUN or RESP.
- **`iv_load[N]`:**
  - Loads `chainN` in any state.
  - If it coincides with a chain update on the same channel, `iv_load` wins.
  - An in-flight block keeps its latched `x`.
- **Requester rules:**
  - `reqN_valid` must not depend on `reqN_ready`.
  - Data, decrypt and chain inputs are held stable while valid.
  - Dropping valid before accept is legal (request withdrawn).
- **Reset** (any state, including mid-RUN): abort the in-flight block, with no response and no chain update. Reset values:
  - state = IDLE; `last_grant` = 1, so channel 0 wins the first tie.
  - `rspN_valid` = 0, `rspN_data` = 0.
  - `des_in` = 0, `des_decrypt` = 0, `des_roundSel` = 0.
  - `chain0` = `chain1` = 0.
  - `busy` = 0, `grant_id` = 0, `reqN_ready` = 0.

## Timing
- Accept edge E0, then RUN for 16 cycles (`roundSel` 0..15).
- `rspN_valid` first high in the 17th cycle after E0.
- With `rspN_ready` held high:
  - RESP lasts 1 cycle.
  - IDLE lasts 1 cycle before the next accept.
  - Total: 18 cycles per block, accept to accept.
- `des_in` and `des_decrypt` are stable for the whole RUN window.
- `busy` rises the cycle after E0 and falls the cycle after the response handshake.
- The core is combinational on the registered `roundSel`; `des_out` is sampled on the edge that ends the `roundSel` == 15 cycle.

## Test plan
- **Single encrypt:** core key 0x133457799BBCDFF1, `req0` encrypt 0x0123456789ABCDEF, `rsp0_ready` = 1 -> `rsp0_data` = 0x85E813540F0AB405, `rsp0_valid` 17 cycles after accept, pulse width 1.
- **Decrypt round trip:** `req1` decrypt 0x85E813540F0AB405 -> `rsp1_data` = 0x0123456789ABCDEF; `grant_id` = 1 throughout.
- **Contention:** both channels hold valid for 4 blocks each -> grants alternate 0,1,0,1,...; each block completes in 18 cycles; no starvation.
- **CBC:**
  - Load IV 0x1111111111111111 on ch0 and encrypt two chained blocks.
  - Load the same IV on ch1 and decrypt both ciphertexts chained -> original plaintexts recovered.
  - `iv_load` on the capture cycle -> `chain` = IV.
- **Backpressure:** hold `rsp0_ready` = 0 for 10 cycles with `req1_valid` = 1 -> `rsp0_data` stable, `req1_ready` stays 0, `req1` accepted 1 cycle after the ch0 handshake.
- **Mid-run reset:** assert reset at `roundSel` = 7 -> next cycle all outputs at reset values, no `rsp_valid`, chains = 0, the next tie grants ch0.

Source files
------------

// File: rtl/des_core_arbiter.sv
// des_core_arbiter
// Shares one iterative DES core between two requester channels. A block is
// granted round-robin, the core's 16 rounds are stepped through roundSel,
// and the result is held for the owning channel until it is consumed.
// Optional per-channel CBC chaining folds the chain value in on the way in
// (encrypt) or on the way out (decrypt).
//
// Ports (N = 0, 1):
//   clk1, reset          clock; synchronous active-high reset
//   reqN_valid/ready     block handshake; ready is combinational, IDLE only
//   reqN_data            64-bit input block
//   reqN_decrypt         1 = decrypt, 0 = encrypt
//   reqN_chain           apply CBC to this block
//   rspN_valid/ready     result handshake
//   rspN_data            64-bit result block
//   iv, iv_load[N]       shared IV bus; bit N loads chainN
//   des_in, des_decrypt  to the core, stable for the whole RUN window
//   des_roundSel         round select driven to the core
//   des_out              combinational core output
//   busy                 high outside IDLE
//   grant_id             channel owning the core
module des_core_arbiter #(
    parameter int CHAIN_EN = 1
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_data,
    input  logic        req0_decrypt,
    input  logic        req0_chain,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_data,
    input  logic        req1_decrypt,
    input  logic        req1_chain,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_data,
    input  logic [63:0] iv,
    input  logic [1:0]  iv_load,
    output logic [63:0] des_in,
    output logic        des_decrypt,
    output logic [3:0]  des_roundSel,
    input  logic [63:0] des_out,
    output logic        busy,
    output logic        grant_id
);

    localparam bit CHAIN_ON = (CHAIN_EN != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        grant_sel;
    logic        accept;
    logic        chained;
    logic [63:0] saved_in;
    logic [63:0] x;
    logic [63:0] chain0;
    logic [63:0] chain1;
    logic [63:0] sel_data;
    logic [63:0] sel_x;
    logic [63:0] result;
    logic [63:0] chain_upd;
    logic        sel_decrypt;
    logic        sel_chain;
    logic        rsp_ready_sel;
    logic        capture;
    logic        handshake;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On a tie the channel that was not served last wins.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        grant_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (des_roundSel == 4'd15) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_data      = grant_sel ? req1_data    : req0_data;
    assign sel_decrypt   = grant_sel ? req1_decrypt : req0_decrypt;
    assign sel_chain     = grant_sel ? req1_chain   : req0_chain;
    assign sel_x         = (CHAIN_ON && sel_chain) ? (grant_sel ? chain1 : chain0) : 64'd0;
    assign result        = des_out ^ (des_decrypt ? x : 64'd0);
    assign chain_upd     = des_decrypt ? saved_in : result;
    assign rsp_ready_sel = grant_id ? rsp1_ready : rsp0_ready;
    assign capture       = (state == RUN) && (des_roundSel == 4'd15);
    assign handshake     = (state == RESP) && rsp_ready_sel;
    assign busy          = (state != IDLE);

    // x is latched at accept so a later iv_load cannot disturb an in-flight
    // block. A chain update at capture is written before iv_load, so an
    // iv_load on the same edge takes precedence.
    always_ff @(posedge clk1) begin
        if (reset) begin
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            chained      <= 1'b0;
            saved_in     <= 64'd0;
            x            <= 64'd0;
            des_in       <= 64'd0;
            des_decrypt  <= 1'b0;
            des_roundSel <= 4'd0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_data    <= 64'd0;
            rsp1_data    <= 64'd0;
            chain0       <= 64'd0;
            chain1       <= 64'd0;
        end else begin
            if (accept) begin
                grant_id     <= grant_sel;
                chained      <= CHAIN_ON && sel_chain;
                saved_in     <= sel_data;
                x            <= sel_x;
                des_in       <= sel_data ^ (sel_decrypt ? 64'd0 : sel_x);
                des_decrypt  <= sel_decrypt;
                des_roundSel <= 4'd0;
            end
            if (state == RUN) begin
                des_roundSel <= des_roundSel + 4'd1;
            end
            if (capture) begin
                if (grant_id) begin
                    rsp1_data  <= result;
                    rsp1_valid <= 1'b1;
                    if (chained) begin
                        chain1 <= chain_upd;
                    end
                end else begin
                    rsp0_data  <= result;
                    rsp0_valid <= 1'b1;
                    if (chained) begin
                        chain0 <= chain_upd;
                    end
                end
            end
            if (handshake) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
                last_grant <= grant_id;
            end
            if (CHAIN_ON && iv_load[0]) begin
                chain0 <= iv;
            end
            if (CHAIN_ON && iv_load[1]) begin
                chain1 <= iv;
            end
        end
    end

endmodule
